// File: rtl/clk_sched_pkg.sv
// ============================================================================
//  Module      : clk_sched_pkg
//  Description : Shared types and default sizes for the clock-strobe
//                scheduler (channel state encoding, default channel count
//                and divisor width).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_sched_pkg;

  // Default number of strobe channels and divisor/counter width
  localparam int CLK_SCHED_CHANNELS = 4;
  localparam int CLK_SCHED_WIDTH    = 16;

  // Per-channel life cycle: stopped, counting, counting with a queued divisor
  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_RUN     = 2'd1,
    CH_PENDING = 2'd2
  } ch_state_e;

endpackage : clk_sched_pkg

`default_nettype wire

// File: rtl/clk_sched_channel.sv
// ============================================================================
//  Module      : clk_sched_channel
//  Description : One strobe channel: divider counter, IDLE/RUN/PENDING FSM,
//                pending-divisor register and registered strobe flop.
//                Divisor changes and stops take effect only at the wrap
//                point (or immediately under align), so every emitted
//                period is either the old or the new length, never a runt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_sched_channel
  import clk_sched_pkg::*;
#(
  parameter int WIDTH = CLK_SCHED_WIDTH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ena_i,
  input  logic             align_i,
  input  logic             cfg_we_i,
  input  logic [WIDTH-1:0] cfg_div_i,
  input  logic [WIDTH-1:0] cfg_phase_i,
  output logic             strobe_o,
  output logic             active_o,
  output logic             pending_o
);

  localparam logic [1:0] ST_IDLE    = CH_IDLE;
  localparam logic [1:0] ST_RUN     = CH_RUN;
  localparam logic [1:0] ST_PENDING = CH_PENDING;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             strobe_q, strobe_d;
  logic             active_q;

  logic             wrap_w;
  logic [WIDTH-1:0] start_cnt_w;
  logic [WIDTH-1:0] cfg_last_w;

  // Counter reaches the last count of the current period
  assign wrap_w      = (cnt_q == (div_q - WIDTH'(1)));
  // Starting count for a fresh start: phase clamped into [0, D-1]
  assign cfg_last_w  = cfg_div_i - WIDTH'(1);
  assign start_cnt_w = (cfg_phase_i > cfg_last_w) ? cfg_last_w : cfg_phase_i;

  // Next-state logic: align/direct-apply takes priority over normal counting
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    pend_d   = pend_q;
    strobe_d = 1'b0;

    if (align_i) begin
      // Phase restart of a live channel; a queued divisor is applied now
      if (state_q == ST_RUN) begin
        cnt_d = '0;
      end else if (state_q == ST_PENDING) begin
        cnt_d = '0;
        if (pend_q != '0) begin
          div_d   = pend_q;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // A config landing on the same edge is applied directly, never queued
      if (cfg_we_i) begin
        if (cfg_div_i != '0) begin
          state_d = ST_RUN;
          div_d   = cfg_div_i;
          cnt_d   = start_cnt_w;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
    end else begin
      if ((state_q != ST_IDLE) && ena_i) begin
        if (wrap_w) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
          if (state_q == ST_PENDING) begin
            if (pend_q != '0) begin
              div_d   = pend_q;
              state_d = ST_RUN;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      // Accepted config: start an idle channel, or queue on a running one
      if (cfg_we_i) begin
        if (state_q == ST_IDLE) begin
          if (cfg_div_i != '0) begin
            state_d = ST_RUN;
            div_d   = cfg_div_i;
            cnt_d   = start_cnt_w;
          end
        end else if (state_q == ST_RUN) begin
          pend_d  = cfg_div_i;
          state_d = ST_PENDING;
        end
      end
    end
  end

  // State, counter, divisor, pending value and output flops
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      pend_q   <= '0;
      strobe_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      strobe_q <= strobe_d;
      active_q <= (state_d != ST_IDLE);
    end
  end

  assign strobe_o  = strobe_q;
  assign active_o  = active_q;
  assign pending_o = (state_q == ST_PENDING);

endmodule : clk_sched_channel

`default_nettype wire

// File: rtl/clk_strobe_scheduler.sv
// ============================================================================
//  Module      : clk_strobe_scheduler
//  Description : Multi-channel programmable clock-enable generator. Decodes
//                the config port onto per-channel write strobes, muxes the
//                ready back from the addressed channel and fans align out.
//                Optional macro CLK_SCHED_PHASE_EN adds cfg_phase_i, the
//                starting count loaded on a fresh start.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_strobe_scheduler
  import clk_sched_pkg::*;
#(
  parameter int CHANNELS = CLK_SCHED_CHANNELS,
  parameter int WIDTH    = CLK_SCHED_WIDTH
) (
  input  logic                                           clk,
  input  logic                                           nrst,
  input  logic                                           ena_i,
  input  logic                                           cfg_valid_i,
  output logic                                           cfg_ready_o,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch_i,
  input  logic [WIDTH-1:0]                               cfg_div_i,
`ifdef CLK_SCHED_PHASE_EN
  input  logic [WIDTH-1:0]                               cfg_phase_i,
`endif
  input  logic                                           align_req_i,
  output logic [CHANNELS-1:0]                            strobe_o,
  output logic [CHANNELS-1:0]                            active_o
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] pending_w;
  logic [CHANNELS-1:0] cfg_we_w;
  logic [WIDTH-1:0]    phase_w;

`ifdef CLK_SCHED_PHASE_EN
  assign phase_w = cfg_phase_i;
`else
  assign phase_w = '0;
`endif

  // Ready drops only while the addressed channel holds a queued divisor;
  // an out-of-range index matches nothing and is therefore always ready
  always_comb begin
    cfg_ready_o = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if ((cfg_ch_i == CH_W'(i)) && pending_w[i]) begin
        cfg_ready_o = 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam logic [CH_W-1:0] CH_IDX = CH_W'(gi);

    assign cfg_we_w[gi] = cfg_valid_i && (cfg_ch_i == CH_IDX) && !pending_w[gi];

    clk_sched_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .clk         (clk),
      .nrst        (nrst),
      .ena_i       (ena_i),
      .align_i     (align_req_i),
      .cfg_we_i    (cfg_we_w[gi]),
      .cfg_div_i   (cfg_div_i),
      .cfg_phase_i (phase_w),
      .strobe_o    (strobe_o[gi]),
      .active_o    (active_o[gi]),
      .pending_o   (pending_w[gi])
    );
  end

endmodule : clk_strobe_scheduler

`default_nettype wire

// File: tb/tb_clk_strobe_scheduler.sv
// ============================================================================
//  Module      : tb_clk_strobe_scheduler
//  Description : Self-checking bench for clk_strobe_scheduler. A countdown
//                model (edges remaining until the next strobe) predicts
//                strobe, active and cfg_ready every cycle; directed cases
//                pin the model with literal expectations, then random
//                traffic runs against it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_strobe_scheduler;

  localparam int CH = 4;
  localparam int W  = 16;
`ifdef CLK_SCHED_PHASE_EN
  localparam bit PH_EN = 1'b1;
`else
  localparam bit PH_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          ena = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_ch = '0;
  logic [W-1:0]  cfg_div = '0;
  logic [W-1:0]  cfg_phase = '0;
  logic          align_req = 1'b0;
  logic [CH-1:0] strobe;
  logic [CH-1:0] active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_strobe_scheduler #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .ena_i       (ena),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_ch_i    (cfg_ch),
    .cfg_div_i   (cfg_div),
`ifdef CLK_SCHED_PHASE_EN
    .cfg_phase_i (cfg_phase),
`endif
    .align_req_i (align_req),
    .strobe_o    (strobe),
    .active_o    (active)
  );

  // Model: mode 0 stopped, 1 running, 2 running with queued divisor.
  // rem = enabled edges left until the edge that produces the next strobe.
  int      md  [CH];
  int      dv  [CH];
  int      pv  [CH];
  int      rem [CH];
  bit [CH-1:0] m_strobe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit m_ready(input int ch);
    return !(ch < CH && md[ch] == 2);
  endfunction

  function automatic bit [CH-1:0] m_active();
    bit [CH-1:0] a;
    for (int i = 0; i < CH; i++) a[i] = (md[i] != 0);
    return a;
  endfunction

  // Fresh start of channel i with divisor d
  task automatic m_start(input int i, input int d);
    int ph;
    ph = PH_EN ? int'(cfg_phase) : 0;
    if (ph > d - 1) ph = d - 1;
    md[i]  = 1;
    dv[i]  = d;
    rem[i] = d - ph;
  endtask

  // Advance the model by one clk edge using the inputs present before it
  task automatic m_edge();
    bit acc;
    int ch;
    ch = int'(cfg_ch);
    if (!nrst) begin
      for (int i = 0; i < CH; i++) begin
        md[i] = 0; dv[i] = 0; pv[i] = 0; rem[i] = 0;
      end
      m_strobe = '0;
      return;
    end
    acc = cfg_valid && m_ready(ch) && (ch < CH);
    for (int i = 0; i < CH; i++) begin
      bit s;
      s = 1'b0;
      if (align_req) begin
        if (md[i] == 2) begin
          if (pv[i] != 0) begin md[i] = 1; dv[i] = pv[i]; rem[i] = dv[i]; end
          else md[i] = 0;
        end else if (md[i] == 1) begin
          rem[i] = dv[i];
        end
        if (acc && ch == i) begin
          if (cfg_div != 0) m_start(i, int'(cfg_div));
          else md[i] = 0;
        end
      end else begin
        if (md[i] != 0 && ena) begin
          rem[i]--;
          if (rem[i] == 0) begin
            s = 1'b1;
            if (md[i] == 2) begin
              if (pv[i] != 0) begin md[i] = 1; dv[i] = pv[i]; end
              else md[i] = 0;
            end
            rem[i] = dv[i];
          end
        end
        if (acc && ch == i) begin
          if (md[i] == 0) begin
            if (cfg_div != 0) m_start(i, int'(cfg_div));
          end else if (md[i] == 1) begin
            pv[i] = int'(cfg_div);
            md[i] = 2;
          end
        end
      end
      m_strobe[i] = s;
    end
  endtask

  // One cycle: check ready for the current request, clock, check outputs
  task automatic step();
    #1;
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready(int'(cfg_ch))));
    @(posedge clk);
    m_edge();
    #1;
    chk("strobe", 32'(strobe), 32'(m_strobe));
    chk("active", 32'(active), 32'(m_active()));
  endtask

  task automatic send(input int ch, input int d);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = W'(d);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_strobe(input int ch, input int maxn, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!strobe[ch] && n < maxn);
  endtask

  initial begin
    int n;
    int f0, f1;
    for (int i = 0; i < CH; i++) begin md[i] = 0; dv[i] = 0; pv[i] = 0; rem[i] = 0; end
    m_strobe = '0;

    // Reset state
    nrst = 1'b0;
    step(); step();
    chk("reset_strobe", 32'(strobe), 32'h0);
    chk("reset_active", 32'(active), 32'h0);
    chk("reset_ready", 32'(cfg_ready), 32'h1);
    nrst = 1'b1;
    ena  = 1'b1;
    step();

    // ch0 D=4: first strobe 4 edges after acceptance, then every 4
    send(0, 4);
    wait_strobe(0, 10, n);
    chk("ch0_first", 32'(n), 32'd4);
    chk("ch0_only", 32'(strobe), 32'h1);
    chk("ch0_active", 32'(active[0]), 32'h1);
    wait_strobe(0, 10, n);
    chk("ch0_period", 32'(n), 32'd4);

    // ch1 D=5 then D=3 mid-period: ready low until wrap, no short period
    send(1, 5);
    step(); step();
    send(1, 3);
    cfg_ch = 2'd1;
    #1;
    chk("ch1_ready_pend", 32'(cfg_ready), 32'h0);
    wait_strobe(1, 10, n);
    chk("ch1_old_rest", 32'(n), 32'd2);
    #1;
    chk("ch1_ready_after", 32'(cfg_ready), 32'h1);
    wait_strobe(1, 10, n);
    chk("ch1_new_period", 32'(n), 32'd3);

    // ch2 D=6 then stop: one final strobe, then idle
    send(2, 6);
    step();
    send(2, 0);
    wait_strobe(2, 10, n);
    chk("ch2_final", 32'(n), 32'd4);
    chk("ch2_inactive", 32'(active[2]), 32'h0);
    repeat (12) step();
    send(2, 0);
    chk("ch2_idle_d0", 32'(active[2]), 32'h0);

    // ena low freezes everything
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("ena_low_strobe", 32'(strobe), 32'h0);
    end
    ena = 1'b1;
    repeat (8) step();

    // align with ch0 D=4 running and ch1 pending P=2
    send(1, 2);
    align_req = 1'b1;
    step();
    align_req = 1'b0;
    f0 = 0; f1 = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (strobe[0] && f0 == 0) f0 = k;
      if (strobe[1] && f1 == 0) f1 = k;
    end
    chk("align_ch0", 32'(f0), 32'd4);
    chk("align_ch1", 32'(f1), 32'd2);

    // Reset while ch3 pending
    send(3, 9);
    step();
    send(3, 5);
    nrst = 1'b0;
    step();
    chk("rst_pend_strobe", 32'(strobe), 32'h0);
    chk("rst_pend_active", 32'(active), 32'h0);
    nrst = 1'b1;
    repeat (5) step();
    chk("rst_ch3_idle", 32'(active[3]), 32'h0);

`ifdef CLK_SCHED_PHASE_EN
    cfg_phase = W'(5);
    send(0, 8);
    cfg_phase = '0;
    wait_strobe(0, 12, n);
    chk("phase_first", 32'(n), 32'd3);
`endif

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      nrst      = ($urandom_range(0, 499) != 0);
      ena       = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_ch    = 2'($urandom_range(0, CH - 1));
      cfg_div   = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(1, 9));
      cfg_phase = W'($urandom_range(0, 10));
      align_req = ($urandom_range(0, 59) == 0);
      step();
    end
    cfg_valid = 1'b0;
    align_req = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_clk_strobe_scheduler

`default_nettype wire

// File: doc/clk_strobe_scheduler.md
Name: clk_strobe_scheduler

Overview:
- Multi-channel programmable clock-enable generator built on per-channel divider counters.
- Each channel emits single-cycle strobes every D enabled clk cycles. Downstream logic uses these strobes as synchronous slow "clocks" instead of derived clock nets.
- Divisors are configured over a valid/ready port. Ratio changes and stops are deferred to the channel's wrap point, so no runt or stretched periods appear.
- Sits between the register/config layer and any slow-rate consumers (LED blinkers, UART baud ticks, sampling ticks).

Parameters:
- CHANNELS, 4, number of independent strobe channels (1..16).
- WIDTH, 16, divisor and counter width in bits.

Ports:
- clk  input  1  system clock.
- nrst  input  1  synchronous active-low reset.
- ena  input  1  global count enable. When low, all counters freeze and all strobes are 0.
- cfg_valid  input  1  config request valid.
- cfg_ready  output  1  config request accepted this cycle when high together with cfg_valid.
- cfg_ch  input  max(1,$clog2(CHANNELS))  target channel index.
- cfg_div  input  WIDTH  new divisor D. D=0 means stop the channel.
- align_req  input  1  single-cycle pulse that restarts the phase of all active channels.
- strobe  output  CHANNELS  per-channel registered one-cycle strobe.
- active  output  CHANNELS  channel is in RUN or PENDING.

Behaviour:
- Reset is synchronous, on nrst=0 at a clk edge. It sets all channels to IDLE, all counters and divisors to 0, strobe=0, active=0. Reset mid-pending discards the pending value.
- Per-channel states:
  - IDLE: counter held at 0, no strobes.
  - RUN: counting with divisor D.
  - PENDING: counting with old D while new value P waits for the wrap.
- Counting rule in RUN/PENDING with ena=1:
  - If cnt==D-1: cnt<=0, strobe[i]<=1 (the wrap).
  - Otherwise: cnt<=cnt+1, strobe[i]<=0.
  - With ena=0: cnt holds and strobe[i]<=0.
- Timing: config accepted at edge E0 on an IDLE channel with D>=1 gives RUN with cnt=0 after E0. With ena held high, strobe is high for exactly the cycle following edge E0+D, then every D cycles.
- D=1 gives strobe continuously high while ena=1. Maximum D is 2^WIDTH-1.
- Config to an IDLE channel:
  - D>=1: go to RUN.
  - D=0: accepted, no effect.
- Config to a RUN channel: store P, go to PENDING.
- At the wrap in PENDING:
  - P>=1: D<=P, go to RUN. The new period starts counting from 0 at that edge.
  - P=0: go to IDLE after emitting that final strobe.
- cfg_ready = 0 exactly when channel cfg_ch is in PENDING, else 1.
  - cfg_ready may depend on cfg_ch but never on cfg_valid.
  - Out-of-range cfg_ch (>=CHANNELS) gets cfg_ready=1 and the request is dropped silently.
- align_req=1 at an edge:
  - Every RUN/PENDING channel sets cnt<=0 and strobe<=0 that cycle, regardless of ena.
  - PENDING channels apply P immediately: to RUN, or to IDLE if P=0.
- Same-edge align_req and accepted config on the same channel: align first, then config is applied directly.
  - D>=1 gives RUN with D, cnt=0.
  - D=0 gives IDLE.
  - There is no PENDING state in this case.
- A wrap and an accepted config on the same RUN channel at the same edge: the wrap completes with the old D, and the channel enters PENDING with P.
- The active output is registered and updates on the same edge as the state.

Optional Feature:
- Macro CLK_SCHED_PHASE_EN.
- When defined: adds input cfg_phase [WIDTH]. On a start from IDLE (or a direct apply under align_req), cnt is loaded with min(cfg_phase, D-1) instead of 0. The first strobe then comes D-phase edges after acceptance. Deferred PENDING updates ignore cfg_phase and always restart at 0.
- When undefined: no cfg_phase port, and starts always load 0.

Decomposition:
- Package clk_sched_pkg holds:
  - enum ch_state_e {CH_IDLE, CH_RUN, CH_PENDING}, 2-bit.
  - Default localparams for CHANNELS and WIDTH.
- One natural sub-module, clk_sched_channel: one counter, the state FSM, the pending register and the strobe flop. It is instantiated CHANNELS times via generate.
- The top level does cfg_ch decode, cfg_ready muxing and align_req fan-out.

Test Plan:
- Reset then start ch0 with D=4, ena=1: first strobe the cycle after edge E0+4, then every 4 cycles. active[0]=1 and other strobes stay 0.
- ch1 running D=5, send D=3 mid-period: cfg_ready for ch1 drops until the wrap. After the wrap, strobe period becomes 3 with no period shorter than 5 before it.
- ch2 running D=6, send D=0: one final strobe at the next wrap, then active[2]=0 and no further strobes. A later D=0 sent to the IDLE channel is accepted with no change.
- ch0 D=3 and ch1 D=7 running, toggle ena low for 10 cycles: counters freeze and strobes stay 0. Resuming gives exactly the remaining counts to the next strobe.
- Pulse align_req with ch0 D=4 at cnt=2 and ch1 PENDING P=2: both restart at 0. ch1 uses D=2 immediately, and the next strobes land 4 and 2 cycles later.
- Assert nrst=0 while ch3 is PENDING: strobe=0 and active=0 next cycle. After release, ch3 stays IDLE until reconfigured. With CLK_SCHED_PHASE_EN, D=8 and phase=5 give the first strobe 3 edges after acceptance.
